// File: rtl/weight_loader_pkg.sv
// Shared types and parameter-derived helpers for the kernel weight loader.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StDone
    } state_e;

    // Number of stream beats packed into one RAM word.
    function automatic int unsigned calc_ratio(input int unsigned word_width,
                                               input int unsigned in_width);
        return word_width / in_width;
    endfunction

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row counter / kernel count width: must represent the value n itself.
    function automatic int unsigned row_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/weight_word_packer.sv
// Packs narrow stream beats little-endian into one wide word; flush drops a partial word.
module weight_word_packer
    import weight_loader_pkg::*;
#(
    parameter int unsigned pWORD_WIDTH = 64,
    parameter int unsigned pIN_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [pIN_WIDTH-1:0]   in_data,
    output logic                   word_valid,
    output logic [pWORD_WIDTH-1:0] word
);

    localparam int unsigned Ratio = calc_ratio(pWORD_WIDTH, pIN_WIDTH);
    localparam int unsigned BeatW = cnt_width(Ratio);

    logic [BeatW-1:0]       beat_q, beat_d;
    logic [pWORD_WIDTH-1:0] word_q, word_d;
    logic [pWORD_WIDTH-1:0] merged;
    logic                   last_beat;

    assign last_beat = (beat_q == BeatW'(Ratio - 1));

    // The completing beat is merged combinationally so the word is ready on the accept cycle.
    always_comb begin
        merged = word_q;
        merged[int'(beat_q) * pIN_WIDTH +: pIN_WIDTH] = in_data;
    end

    assign word_valid = in_valid && last_beat;
    assign word       = merged;

    always_comb begin
        beat_d = beat_q;
        word_d = word_q;
        if (flush) begin
            beat_d = '0;
            word_d = '0;
        end else if (in_valid) begin
            if (last_beat) begin
                beat_d = '0;
                word_d = '0;
            end else begin
                beat_d = beat_q + BeatW'(1);
                word_d = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            word_q <= '0;
        end else begin
            beat_q <= beat_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams weight beats into the kernel RAM write port, one packed word per write.
// Optional running checksum of written chunks enabled by WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
    parameter int unsigned pIN_WIDTH          = 32,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned pKERNEL_NUM        = 1024,
    parameter int unsigned pULTRA_RAM_NUM     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic [$clog2(pKERNEL_NUM):0]    cfg_kernel_cnt,
    input  logic                            s_valid,
    input  logic [pIN_WIDTH-1:0]            s_data,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic                            wr_en,
    output logic [31:0]                     weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0]   weight_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [31:0]                     checksum
);

    localparam int unsigned Ratio = calc_ratio(pWEIGHT_DATA_WIDTH, pIN_WIDTH);
    localparam int unsigned CntW  = row_width(pKERNEL_NUM);
    localparam int unsigned BankW = cnt_width(pULTRA_RAM_NUM);

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [CntW-1:0]                 row_q, row_d;
    logic [BankW-1:0]                bank_q, bank_d;
    logic                            err_q, err_d;
    logic                            wr_en_q, wr_en_d;
    logic [31:0]                     addr_q, addr_d;
    logic [pWEIGHT_DATA_WIDTH-1:0]   data_q, data_d;

    logic                            accept;
    logic                            pack_valid;
    logic                            pack_flush;
    logic                            word_valid;
    logic [pWEIGHT_DATA_WIDTH-1:0]   word;
    logic                            last_bank;
    logic                            last_row;
    logic                            final_word;
    logic                            start_ok;

    assign busy     = (state_q == StLoad) || (state_q == StDrain);
    assign s_ready  = busy;
    assign done     = (state_q == StDone);
    assign err      = err_q;
    assign wr_en    = wr_en_q;
    assign weight_addr = addr_q;
    assign weight_data = data_q;

    assign accept     = s_valid && s_ready;
    assign pack_valid = accept && (state_q == StLoad);
    assign start_ok   = cfg_start && (state_q == StIdle);

    assign last_bank  = (bank_q == BankW'(pULTRA_RAM_NUM - 1));
    assign last_row   = (row_q == cnt_q - CntW'(1));
    assign final_word = word_valid && last_bank && last_row;

    weight_word_packer #(
        .pWORD_WIDTH (pWEIGHT_DATA_WIDTH),
        .pIN_WIDTH   (pIN_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (pack_flush),
        .in_valid   (pack_valid),
        .in_data    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        bank_d     = bank_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        pack_flush = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    err_d      = 1'b0;
                    row_d      = '0;
                    bank_d     = '0;
                    pack_flush = 1'b1;
                    if (cfg_kernel_cnt == '0) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else if (cfg_kernel_cnt > CntW'(pKERNEL_NUM)) begin
                        cnt_d   = CntW'(pKERNEL_NUM);
                        err_d   = 1'b1;
                        state_d = StLoad;
                    end else begin
                        cnt_d   = cfg_kernel_cnt;
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                if (accept) begin
                    if (word_valid) begin
                        wr_en_d = 1'b1;
                        addr_d  = pWEIGHT_BASE_ADDR + 32'(row_q);
                        data_d  = word;
                        // The RAM rotates banks per write, so the row holds for a full bank sweep.
                        if (last_bank) begin
                            bank_d = '0;
                            row_d  = row_q + CntW'(1);
                        end else begin
                            bank_d = bank_q + BankW'(1);
                        end
                        if (final_word) begin
                            if (s_last) begin
                                state_d = StDone;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StDrain;
                            end
                        end else if (s_last) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end
                    end else if (s_last) begin
                        pack_flush = 1'b1;
                        err_d      = 1'b1;
                        state_d    = StDone;
                    end
                end
            end

            StDrain: begin
                if (accept && s_last) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
            bank_q  <= '0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= pWEIGHT_BASE_ADDR;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d, chunk_sum;

    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < int'(Ratio); i++) begin
            chunk_sum = chunk_sum + 32'(word[i * pIN_WIDTH +: pIN_WIDTH]);
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (pack_valid && word_valid) begin
            sum_d = sum_q + chunk_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: stimulus queues expected writes, a monitor checks them.
module tb_weight_loader;

    localparam int unsigned W    = 64;
    localparam int unsigned IN   = 32;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [10:0]   cfg_kernel_cnt;
    logic          s_valid;
    logic [IN-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          wr_en;
    logic [31:0]   weight_addr;
    logic [W-1:0]  weight_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   checksum;

    typedef struct packed {
        logic [31:0]  addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sum = '0;

    weight_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_kernel_cnt (cfg_kernel_cnt),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .wr_en          (wr_en),
        .weight_addr    (weight_addr),
        .weight_data    (weight_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write: addr %h data %h, expected no write",
                         weight_addr, weight_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write addr", 64'(weight_addr), 64'(mon_e.addr));
                chk("write data", weight_data, mon_e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] beat_val(input int t, input int i);
        return {8'(t), 24'(i * 37 + 5)};
    endfunction

    function automatic logic [31:0] exp_cs();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 32'h0;
`endif
    endfunction

    task automatic expect_word(input int k, input logic [31:0] lo, input logic [31:0] hi);
        wr_t e;
        e.addr = BASE + 32'(k / 8);
        e.data = {hi, lo};
        exp_q.push_back(e);
        exp_sum = exp_sum + lo + hi;
    endtask

    task automatic start(input logic [10:0] cnt);
        cfg_kernel_cnt = cnt;
        cfg_start      = 1'b1;
        @(posedge clk); #1;
        cfg_start      = 1'b0;
        exp_sum        = '0;
    endtask

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d, input logic last, input bit gap);
        logic rdy;
        int   n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL beat accept timeout: s_ready 0 for 50 cycles, expected 1");
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Sends n beats of tag t; words are expected for beats below n_words*2.
    task automatic send_run(input int t, input int n, input int n_words, input int last_at,
                            input bit gap);
        logic [31:0] lo;
        logic [31:0] d;
        lo = '0;
        for (int i = 0; i < n; i++) begin
            d = beat_val(t, i);
            if (i[0] == 1'b0) lo = d;
            else if (i / 2 < n_words) expect_word(i / 2, lo, d);
            send_beat(d, i == last_at, gap && (i != n - 1));
        end
    endtask

    task automatic check_end(input string tag, input logic exp_err);
        @(negedge clk);
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        chk({tag, " busy at done"}, 64'(busy), 64'(0));
        chk({tag, " s_ready at done"}, 64'(s_ready), 64'(0));
        chk({tag, " checksum"}, 64'(checksum), 64'(exp_cs()));
        @(negedge clk);
        chk({tag, " done width"}, 64'(done), 64'(0));
        chk({tag, " missing writes"}, 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " s_ready"}, 64'(s_ready), 64'(0));
        chk({tag, " wr_en"}, 64'(wr_en), 64'(0));
        chk({tag, " addr"}, 64'(weight_addr), 64'(BASE));
        chk({tag, " data"}, weight_data, 64'(0));
        chk({tag, " busy"}, 64'(busy), 64'(0));
        chk({tag, " done"}, 64'(done), 64'(0));
        chk({tag, " err"}, 64'(err), 64'(0));
        chk({tag, " checksum"}, 64'(checksum), 64'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_kernel_cnt = '0;
        s_valid        = 1'b0;
        s_data         = '0;
        s_last         = 1'b0;
        #12;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two rows, continuous stream, s_last on the final beat.
        start(11'd2);
        send_run(1, 32, 16, 31, 1'b0);
        check_end("cnt2", 1'b0);

        // One row with s_valid gaps and an ignored mid-run start.
        start(11'd1);
        begin
            logic [31:0] lo;
            logic [31:0] d;
            lo = '0;
            for (int i = 0; i < 16; i++) begin
                d = beat_val(1, i);
                if (i[0] == 1'b0) lo = d;
                else expect_word(i / 2, lo, d);
                send_beat(d, i == 15, 1'b0);
                if (i == 6) begin
                    cfg_kernel_cnt = 11'd3;
                    cfg_start      = 1'b1;
                    @(posedge clk); #1;
                    cfg_start      = 1'b0;
                end else if (i != 15) begin
                    @(posedge clk); #1;
                end
            end
        end
        check_end("gaps", 1'b0);

        // Early s_last on beat 5: partial word dropped.
        start(11'd1);
        send_run(2, 5, 2, 4, 1'b0);
        check_end("early last", 1'b1);

        // Overlong stream: final write, then drain until s_last.
        start(11'd1);
        send_run(3, 16, 8, -1, 1'b0);
        @(negedge clk);
        chk("overlong err after final write", 64'(err), 64'(1));
        chk("overlong still busy", 64'(busy), 64'(1));
        chk("overlong no done yet", 64'(done), 64'(0));
        @(posedge clk); #1;
        for (int i = 16; i < 20; i++) send_beat(beat_val(3, i), i == 19, 1'b0);
        check_end("overlong", 1'b1);

        // Zero rows: done next cycle, no writes.
        start(11'd0);
        @(negedge clk);
        chk("cnt0 done", 64'(done), 64'(1));
        chk("cnt0 busy", 64'(busy), 64'(0));
        chk("cnt0 err", 64'(err), 64'(0));
        @(negedge clk);
        chk("cnt0 done width", 64'(done), 64'(0));
        @(posedge clk); #1;

        // Clamped count: 1025 rows becomes 1024.
        start(11'd1025);
        @(negedge clk);
        chk("clamp err", 64'(err), 64'(1));
        chk("clamp busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        send_run(6, 16384, 8192, 16383, 1'b0);
        check_end("clamp", 1'b1);

        // Reset after three writes, then a clean reload.
        start(11'd1);
        send_run(4, 6, 3, -1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid-run reset");
        chk("mid-run reset writes seen", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start(11'd1);
        send_run(7, 16, 8, 15, 1'b0);
        check_end("after reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
